ysyx_23060278_ifu: RTL
======================

# ysyx_23060278_ifu

Instruction fetch unit, directly downstream of the PC register. Accepts a PC when the PC register updates, reads one 32-bit instruction over an AXI4-Lite read channel (AR/R), and hands it with its PC to the decode stage over a valid/ready handshake. One instruction is in flight at a time; a redirect flush discards it.

## Interface
- ADDR_W, 32, address and PC width
- DATA_W, 32, instruction width (only 32 supported)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- pc  in  ADDR_W  PC to fetch, from the PC register
- pc_valid  in  1  one-cycle pulse: pc holds a new fetch address
- flush  in  1  redirect; discard the in-flight fetch
- araddr  out  ADDR_W  read address
- arvalid  out  1  read address valid
- arready  in  1  memory accepts address
- rdata  in  DATA_W  read data
- rresp  in  2  read response; non-zero = error
- rvalid  in  1  read data valid
- rready  out  1  IFU accepts read data
- inst  out  DATA_W  fetched instruction
- inst_pc  out  ADDR_W  PC of inst
- inst_fault  out  2  00 ok, 01 access fault, 10 misaligned
- inst_valid  out  1  inst/inst_pc/inst_fault valid to decode
- inst_ready  in  1  decode accepts instruction

## Operation
- FSM states: IDLE, AR, R, OUT.
- IDLE: when pc_valid is high, latch pc into the address register and go to AR. pc_valid is ignored in every other state.
- AR: arvalid=1, araddr held stable. When arready is high, go to R.
- R: rready=1. When rvalid is high, capture rdata into inst; inst_fault=01 if rresp!=0, else 00. Go to OUT.
- OUT: inst_valid=1, all inst_* outputs held stable. When inst_ready is high, go to IDLE.
- inst_pc is the latched pc. araddr = {pc[31:2],2'b00}.
- Flush, by state:
  - IDLE: no effect, except that a simultaneous pc_valid is still accepted. The new PC wins.
  - AR: set a drop flag. arvalid stays high until the handshake completes, per the AXI no-retract rule.
  - R with drop flag set: on rvalid, return to IDLE without entering OUT.
  - OUT: drop inst_valid and go to IDLE next cycle, even if inst_ready is high in the same cycle.
- The drop flag clears on entry to IDLE.
- rresp is only sampled on the rvalid && rready cycle.

## Timing
- Reset values (async assert, sync-safe deassert):
  - state=IDLE
  - arvalid=0, rready=0, inst_valid=0
  - inst=0, inst_pc=0, inst_fault=00
  - araddr=0, drop flag=0
- Minimum latency, with arready and rvalid returning as early as possible:
  - pc_valid @ cycle 0 → arvalid @ 1
  - arready @ 1 → rready @ 2
  - rvalid @ 2 → inst_valid @ 3
- Every added memory wait cycle adds exactly one cycle of latency.
- All outputs are registered; no combinational path from inputs to outputs.
- Back-to-back fetches: at best one instruction every 4 cycles (IDLE is visited between fetches).
- Reset mid-transaction returns to IDLE immediately. The memory side must also be reset.

## Configuration
- YSYX_23060278_IFU_MISALIGN_CHECK_EN
  - Defined: in IDLE, pc_valid with pc[1:0]!=0 skips AR/R and goes straight to OUT with inst=0 and inst_fault=10. No bus transaction is issued.
  - Undefined: pc[1:0] is ignored. The word-aligned fetch proceeds normally and inst_fault=10 is never produced.

## Structure
- Shared package ysyx_23060278_pkg holds:
  - FSM state enum
  - fault codes: FAULT_NONE=2'b00, FAULT_ACCESS=2'b01, FAULT_MISALIGN=2'b10
  - RESET_PC=32'h80000000
- Single module with no sub-module. The FSM and output registers are small enough to live inline.

## Test plan
- Basic fetch: pc=0x80000000 pulse; arready=1 on the first arvalid cycle; rvalid next with rdata=0x00000413, rresp=0. Expect araddr=0x80000000, inst_valid at cycle 3, inst=0x00000413, inst_pc=0x80000000, fault=00.
- Slow memory: arready delayed 3 cycles, rvalid delayed 2 cycles. Expect arvalid and araddr stable throughout; inst_valid at cycle 8. Hold inst_ready=0 for 4 cycles: expect outputs stable.
- Access error: rresp=2'b10, rdata=0xDEADBEEF. Expect inst_valid with inst_fault=01, inst=0xDEADBEEF.
- Flush in AR and in OUT:
  - Flush while arvalid=1, arready held 0: arvalid stays high until arready; rvalid is consumed with no inst_valid; the next pc_valid=0x80000010 fetches normally.
  - Flush during OUT with inst_ready=1: the instruction is not consumed; state returns to IDLE.
- Misalign, macro defined: pc=0x80000002. Expect no arvalid, and inst_valid at cycle 1 with fault=10, inst=0. Macro undefined: araddr=0x80000000, fault=00.
- Reset mid-R: assert rst_n=0 while rready=1. Expect rready=0 and inst_valid=0 immediately, state IDLE; after release, a pc_valid pulse fetches normally.

Source files
------------

// File: rtl/ysyx_23060278_ifu_pkg.sv
// ============================================================================
// Package : ysyx_23060278_pkg
// Desc    : Shared IFU types: FSM state encoding, fault codes, reset PC.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_23060278_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_OUT  = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_ACCESS   = 2'b01;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b10;

  localparam logic [31:0] RESET_PC       = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/ysyx_23060278_ifu_if.sv
// ============================================================================
// Interface : ysyx_23060278_ifu_if
// Desc      : AXI4-Lite read channel (AR/R) between the IFU and instruction memory.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface ysyx_23060278_ifu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

`default_nettype wire

// File: rtl/ysyx_23060278_ifu.sv
// ============================================================================
// Module : ysyx_23060278_ifu
// Desc   : Single-outstanding instruction fetch: PC in, AXI4-Lite read, inst out.
// Config : YSYX_23060278_IFU_MISALIGN_CHECK_EN (misaligned PC faults without a bus read)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_23060278_ifu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic [ADDR_W-1:0] pc,
  input  wire logic              pc_valid,
  input  wire logic              flush,
  ysyx_23060278_ifu_if.master    axi,
  output logic [DATA_W-1:0]      inst,
  output logic [ADDR_W-1:0]      inst_pc,
  output logic [1:0]             inst_fault,
  output logic                   inst_valid,
  input  wire logic              inst_ready
);

  import ysyx_23060278_pkg::*;

  ifu_state_e        state, state_nxt;
  logic              drop, drop_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [DATA_W-1:0] inst_nxt;
  logic [1:0]        fault_nxt;
  logic              arvalid, rready;

  assign axi.araddr  = addr;
  assign axi.arvalid = arvalid;
  assign axi.rready  = rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      drop       <= 1'b0;
      addr       <= '0;
      inst_pc    <= '0;
      inst       <= '0;
      inst_fault <= FAULT_NONE;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      drop       <= drop_nxt;
      addr       <= addr_nxt;
      inst_pc    <= pc_nxt;
      inst       <= inst_nxt;
      inst_fault <= fault_nxt;
      // Handshake outputs are decoded from the next state so they leave a flop.
      arvalid    <= (state_nxt == ST_AR);
      rready     <= (state_nxt == ST_R);
      inst_valid <= (state_nxt == ST_OUT);
    end
  end

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    addr_nxt  = addr;
    pc_nxt    = inst_pc;
    inst_nxt  = inst;
    fault_nxt = inst_fault;

    case (state)
      ST_IDLE: begin
        if (pc_valid) begin
          pc_nxt   = pc;
          addr_nxt = {pc[ADDR_W-1:2], 2'b00};
`ifdef YSYX_23060278_IFU_MISALIGN_CHECK_EN
          if (pc[1:0] != 2'b00) begin
            inst_nxt  = '0;
            fault_nxt = FAULT_MISALIGN;
            state_nxt = ST_OUT;
          end else begin
            state_nxt = ST_AR;
          end
`else
          state_nxt = ST_AR;
`endif
        end
      end

      ST_AR: begin
        // AXI forbids retracting arvalid, so a flush only marks the beat for discard.
        if (flush) drop_nxt = 1'b1;
        if (axi.arready) state_nxt = ST_R;
      end

      ST_R: begin
        if (flush) drop_nxt = 1'b1;
        if (axi.rvalid) begin
          if (drop || flush) begin
            state_nxt = ST_IDLE;
          end else begin
            inst_nxt  = axi.rdata;
            fault_nxt = (axi.rresp != 2'b00) ? FAULT_ACCESS : FAULT_NONE;
            state_nxt = ST_OUT;
          end
        end
      end

      ST_OUT: begin
        if (flush || inst_ready) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase

    if (state_nxt == ST_IDLE) drop_nxt = 1'b0;
  end

endmodule

`default_nettype wire
